// File: rtl/vreg_wb_arbiter_pkg.sv
// Shared vector register file types: element/vector widths, select type,
// and requester indices used by the writeback arbiter, regfile and decode.
package vreg_pkg;
  localparam int REG_SIZE = 16;  // bits per vector element
  localparam int REG_QTY  = 4;   // number of vector registers
  localparam int SEL_BITS = 2;   // log2(REG_QTY)
  localparam int VEC_SIZE = 4;   // elements per vector

  localparam int REQ_ALU  = 0;
  localparam int REQ_LOAD = 1;

  typedef logic [SEL_BITS-1:0]                reg_sel_t;
  typedef logic [VEC_SIZE-1:0][REG_SIZE-1:0]  vec_t;

  // One-hot register mask for a select value
  function automatic logic [REG_QTY-1:0] sel_onehot(input reg_sel_t s);
    return REG_QTY'(1) << s;
  endfunction
endpackage

// File: rtl/vreg_wb_arbiter_rr_arbiter2.sv
// Two-way round-robin arbiter. ptr_q=0 favours req[0]; after a grant the
// pointer moves to the other side. hold freezes the pointer (flush).
module rr_arbiter2 (
  input  logic       clk,
  input  logic       rst,
  input  logic       hold,
  input  logic [1:0] req,
  output logic [1:0] gnt
);
  logic       ptr_q, ptr_d;
  logic [1:0] gnt_c;

  // Grant: lone requester wins, contention goes to the pointer side
  always_comb begin
    gnt_c[0] = req[0] & (~req[1] | ~ptr_q);
    gnt_c[1] = req[1] & (~req[0] |  ptr_q);
    ptr_d    = ptr_q;
    if (!hold && (gnt_c != 2'b00)) ptr_d = gnt_c[0];
  end

  assign gnt = gnt_c;

  // Pointer register, req0 first out of reset
  always_ff @(posedge clk) begin
    if (!rst) ptr_q <= 1'b0;
    else      ptr_q <= ptr_d;
  end
endmodule

// File: rtl/vreg_wb_arbiter.sv
// Writeback arbiter for the vector register file write port. ALU (req0) and
// load unit (req1) share the port round-robin; the winner is registered onto
// the regfile write port. A pending-write scoreboard feeds decode RAW/WAW
// busy flags.
module vreg_wb_arbiter
  import vreg_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 req0Valid,
  input  reg_sel_t             req0Dest,
  input  vec_t                 req0Data,
  output logic                 req0Ready,
  input  logic                 req1Valid,
  input  reg_sel_t             req1Dest,
  input  vec_t                 req1Data,
  output logic                 req1Ready,
  input  logic                 issueEn,
  input  reg_sel_t             issueDest,
  input  reg_sel_t             rSel1,
  input  reg_sel_t             rSel2,
  output logic                 rSel1Busy,
  output logic                 rSel2Busy,
  output logic                 destBusy,
  input  logic                 flush,
  output logic                 regWrEn,
  output reg_sel_t             regToWrite,
  output vec_t                 regWriteData,
  output logic [REG_QTY-1:0]   pendingMask,
  output logic                 errNoPend
);
  logic [1:0]         gnt;
  logic               grant;
  reg_sel_t           g_dest;
  vec_t               g_data;

  logic               wr_en_q,   wr_en_d;
  reg_sel_t           wr_sel_q,  wr_sel_d;
  vec_t               wr_data_q, wr_data_d;
  logic [REG_QTY-1:0] pend_q,    pend_d;
  logic               err_q,     err_d;

  rr_arbiter2 u_rr (
    .clk  (clk),
    .rst  (rst),
    .hold (flush),
    .req  ({req1Valid, req0Valid}),
    .gnt  (gnt)
  );

  // No backpressure past arbitration: ready is the grant itself
  assign req0Ready = gnt[REQ_ALU];
  assign req1Ready = gnt[REQ_LOAD];

  // Winner mux, output-stage next state and scoreboard next state
  always_comb begin
    grant  = |gnt;
    g_dest = gnt[REQ_LOAD] ? req1Dest : req0Dest;
    g_data = gnt[REQ_LOAD] ? req1Data : req0Data;

    // A flushed grant is dropped; select/data hold when nothing is written
    wr_en_d   = grant & ~flush;
    wr_sel_d  = wr_en_d ? g_dest : wr_sel_q;
    wr_data_d = wr_en_d ? g_data : wr_data_q;

    // Clear lands on the regfile capture edge; a same-edge issue wins
    pend_d = pend_q & ~({REG_QTY{wr_en_q}} & sel_onehot(wr_sel_q));
    if (issueEn) pend_d = pend_d | sel_onehot(issueDest);
    if (flush)   pend_d = '0;

    err_d = err_q | (grant & ~pend_q[g_dest]
                     & ~(issueEn && (issueDest == g_dest)));
  end

  // Output stage, scoreboard and sticky error, synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_en_q   <= 1'b0;
      wr_sel_q  <= '0;
      wr_data_q <= '0;
      pend_q    <= '0;
      err_q     <= 1'b0;
    end else begin
      wr_en_q   <= wr_en_d;
      wr_sel_q  <= wr_sel_d;
      wr_data_q <= wr_data_d;
      pend_q    <= pend_d;
      err_q     <= err_d;
    end
  end

  assign regWrEn      = wr_en_q;
  assign regToWrite   = wr_sel_q;
  assign regWriteData = wr_data_q;
  assign pendingMask  = pend_q;
  assign errNoPend    = err_q;
  assign rSel1Busy    = pend_q[rSel1];
  assign rSel2Busy    = pend_q[rSel2];
  assign destBusy     = pend_q[issueDest];
endmodule

// File: tb/tb_vreg_wb_arbiter.sv
// Directed bench for vreg_wb_arbiter: reset, single write, contention,
// set/clear collision, sticky error, flush and reset-in-flight.
module tb_vreg_wb_arbiter;
  import vreg_pkg::*;

  logic               clk = 1'b0;
  logic               rst;
  logic               req0Valid, req1Valid, issueEn, flush;
  reg_sel_t           req0Dest, req1Dest, issueDest, rSel1, rSel2;
  vec_t               req0Data, req1Data;
  logic               req0Ready, req1Ready, rSel1Busy, rSel2Busy, destBusy;
  logic               regWrEn, errNoPend;
  reg_sel_t           regToWrite;
  vec_t               regWriteData;
  logic [REG_QTY-1:0] pendingMask;

  int nvec = 0;
  int nerr = 0;

  always #5 clk = ~clk;

  vreg_wb_arbiter dut (
    .clk(clk), .rst(rst),
    .req0Valid(req0Valid), .req0Dest(req0Dest), .req0Data(req0Data), .req0Ready(req0Ready),
    .req1Valid(req1Valid), .req1Dest(req1Dest), .req1Data(req1Data), .req1Ready(req1Ready),
    .issueEn(issueEn), .issueDest(issueDest),
    .rSel1(rSel1), .rSel2(rSel2), .rSel1Busy(rSel1Busy), .rSel2Busy(rSel2Busy),
    .destBusy(destBusy), .flush(flush),
    .regWrEn(regWrEn), .regToWrite(regToWrite), .regWriteData(regWriteData),
    .pendingMask(pendingMask), .errNoPend(errNoPend)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  vec_t d_a, d_b, x0, x1, d_y, d_z;

  initial begin
    d_a = {16'hA000, 16'hA001, 16'hA002, 16'hA003};
    d_b = {16'd1, 16'd2, 16'd3, 16'd4};
    x0  = {16'h0C00, 16'h0C01, 16'h0C02, 16'h0C03};
    x1  = {16'h1C00, 16'h1C01, 16'h1C02, 16'h1C03};
    d_y = {16'hBEEF, 16'hCAFE, 16'hF00D, 16'h1234};
    d_z = {16'h5555, 16'h6666, 16'h7777, 16'h8888};

    rst = 1'b0; flush = 1'b0; issueEn = 1'b0; issueDest = '0;
    rSel1 = '0; rSel2 = '0;
    req0Valid = 1'b1; req0Dest = 2'd0; req0Data = d_a;
    req1Valid = 1'b0; req1Dest = 2'd0; req1Data = '0;

    // Reset held with req0 valid: nothing leaves the output stage
    tick(); tick();
    chk("rst_wren",  64'(regWrEn), 64'd0);
    chk("rst_pend",  64'(pendingMask), 64'd0);
    chk("rst_err",   64'(errNoPend), 64'd0);
    chk("rst_sel",   64'(regToWrite), 64'd0);
    chk("rst_data",  64'(regWriteData), 64'd0);

    // Release: req0 granted first; same-cycle issue of dest 0 avoids the error
    rst = 1'b1; issueEn = 1'b1; issueDest = 2'd0;
    #1;
    chk("rel_rdy0", 64'(req0Ready), 64'd1);
    chk("rel_rdy1", 64'(req1Ready), 64'd0);
    tick();
    req0Valid = 1'b0; issueEn = 1'b0;
    chk("rel_wren", 64'(regWrEn), 64'd1);
    chk("rel_sel",  64'(regToWrite), 64'd0);
    chk("rel_data", 64'(regWriteData), 64'(d_a));
    chk("rel_pend", 64'(pendingMask), 64'b0001);
    tick();
    chk("rel_clr",  64'(pendingMask), 64'b0000);
    chk("rel_wr0",  64'(regWrEn), 64'd0);
    chk("rel_err",  64'(errNoPend), 64'd0);

    // Single write path via the load unit to register 2
    issueEn = 1'b1; issueDest = 2'd2; rSel1 = 2'd2; rSel2 = 2'd1;
    tick();
    issueEn = 1'b0;
    chk("sw_pend", 64'(pendingMask), 64'b0100);
    chk("sw_busy1", 64'(rSel1Busy), 64'd1);
    chk("sw_busy2", 64'(rSel2Busy), 64'd0);
    tick(); tick();
    req1Valid = 1'b1; req1Dest = 2'd2; req1Data = d_b;
    #1;
    chk("sw_rdy1", 64'(req1Ready), 64'd1);
    chk("sw_rdy0", 64'(req0Ready), 64'd0);
    tick();
    req1Valid = 1'b0;
    chk("sw_wren", 64'(regWrEn), 64'd1);
    chk("sw_sel",  64'(regToWrite), 64'd2);
    chk("sw_data", 64'(regWriteData), 64'(d_b));
    chk("sw_busy_wr", 64'(rSel1Busy), 64'd1);
    tick();
    chk("sw_pend0", 64'(pendingMask), 64'b0000);
    chk("sw_busy_clr", 64'(rSel1Busy), 64'd0);

    // Contention: dests 0 and 1 pending, both requesters valid throughout
    issueEn = 1'b1; issueDest = 2'd0; tick();
    issueDest = 2'd1; tick();
    issueEn = 1'b0;
    chk("ct_pend", 64'(pendingMask), 64'b0011);
    req0Valid = 1'b1; req0Dest = 2'd0; req0Data = x0;
    req1Valid = 1'b1; req1Dest = 2'd1; req1Data = x1;
    for (int k = 0; k < 4; k++) begin
      // Re-issue the register currently being written so it stays pending
      issueEn   = (k > 0);
      issueDest = reg_sel_t'((k - 1) & 1);
      #1;
      chk($sformatf("ct_rdy0_%0d", k), 64'(req0Ready), 64'((k % 2) == 0));
      chk($sformatf("ct_rdy1_%0d", k), 64'(req1Ready), 64'((k % 2) == 1));
      tick();
      chk($sformatf("ct_sel_%0d", k),  64'(regToWrite), 64'(k % 2));
      chk($sformatf("ct_data_%0d", k), 64'(regWriteData), (k % 2) ? 64'(x1) : 64'(x0));
    end
    req0Valid = 1'b0; req1Valid = 1'b0; issueEn = 1'b0;
    chk("ct_err", 64'(errNoPend), 64'd0);
    tick();
    chk("ct_pend_end", 64'(pendingMask), 64'b0001);

    // Set/clear collision on register 3
    issueEn = 1'b1; issueDest = 2'd3; tick();
    issueEn = 1'b0;
    req0Valid = 1'b1; req0Dest = 2'd3; req0Data = d_y;
    tick();
    req0Valid = 1'b0;
    chk("col_wren", 64'(regWrEn), 64'd1);
    chk("col_sel",  64'(regToWrite), 64'd3);
    issueEn = 1'b1; issueDest = 2'd3;
    #1;
    chk("col_destbusy", 64'(destBusy), 64'd1);
    tick();
    issueEn = 1'b0;
    chk("col_pend", 64'(pendingMask), 64'b1001);
    chk("col_err",  64'(errNoPend), 64'd0);

    // Write to a non-pending register sets the sticky error
    req0Valid = 1'b1; req0Dest = 2'd1; req0Data = d_z;
    tick();
    req0Valid = 1'b0;
    chk("err_set",  64'(errNoPend), 64'd1);
    chk("err_wren", 64'(regWrEn), 64'd1);
    chk("err_sel",  64'(regToWrite), 64'd1);
    issueEn = 1'b1; issueDest = 2'd1;
    tick();
    issueEn = 1'b0;
    chk("fl_pre_pend", 64'(pendingMask), 64'b1011);
    chk("err_sticky",  64'(errNoPend), 64'd1);

    // Flush with a grant and an issue in the same cycle
    flush = 1'b1; req1Valid = 1'b1; req1Dest = 2'd2; req1Data = d_y;
    issueEn = 1'b1; issueDest = 2'd2;
    #1;
    chk("fl_rdy1", 64'(req1Ready), 64'd1);
    tick();
    flush = 1'b0; req1Valid = 1'b0; issueEn = 1'b0;
    chk("fl_pend", 64'(pendingMask), 64'b0000);
    chk("fl_wren", 64'(regWrEn), 64'd0);
    chk("fl_sel_hold", 64'(regToWrite), 64'd1);
    chk("fl_err", 64'(errNoPend), 64'd1);

    // Pointer held through flush: still on req1 under contention
    req0Valid = 1'b1; req0Dest = 2'd0; req0Data = x0;
    req1Valid = 1'b1; req1Dest = 2'd3; req1Data = x1;
    #1;
    chk("fl_ptr_rdy1", 64'(req1Ready), 64'd1);
    chk("fl_ptr_rdy0", 64'(req0Ready), 64'd0);
    tick();
    req1Valid = 1'b0;
    chk("fl_ptr_sel", 64'(regToWrite), 64'd3);
    chk("fl_ptr_wr",  64'(regWrEn), 64'd1);

    // Reset with a write in flight: write lost, state cleared
    req0Valid = 1'b0; issueEn = 1'b1; issueDest = 2'd2;
    rst = 1'b0;
    tick();
    rst = 1'b1; issueEn = 1'b0;
    chk("rif_wren", 64'(regWrEn), 64'd0);
    chk("rif_pend", 64'(pendingMask), 64'd0);
    chk("rif_err",  64'(errNoPend), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
